// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Purpose  : 2R/1W register file with pending-write scoreboard and a
//            DEPTH-cycle self-clearing sweep after reset.
// Option   : REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wd,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1,
  output logic [DATA_W-1:0] rs2,
  output logic              rs1_pend,
  output logic              rs2_pend,
  output logic              init_busy
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DEPTH-1:0]    pend;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic rd_writable;
  logic alloc_writable;
  logic wr_ok;
  logic al_ok;

  assign rd_writable    = (ZERO_REG == 0) || (rd_addr != '0);
  assign alloc_writable = (ZERO_REG == 0) || (alloc_addr != '0);
  assign wr_ok          = (state == READY) && we && rd_writable;
  assign al_ok          = (state == READY) && alloc && alloc_writable;

  // Control state, scoreboard and the registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      pend      <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == LAST_IDX) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          if (wr_ok) pend[rd_addr] <= 1'b0;
          // Alloc is applied last so a newer producer keeps the entry pending.
          if (al_ok) pend[alloc_addr] <= 1'b1;
        end
        default: begin
          state     <= CLEAR;
          clr_ptr   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage array has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else if (wr_ok) begin
        regs[rd_addr] <= wd;
      end
    end
  end

  always_comb begin
    rs1      = '0;
    rs2      = '0;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    if (state == READY) begin
      if (!((ZERO_REG != 0) && (rs1_addr == '0))) rs1 = regs[rs1_addr];
      if (!((ZERO_REG != 0) && (rs2_addr == '0))) rs2 = regs[rs2_addr];
      rs1_pend = pend[rs1_addr];
      rs2_pend = pend[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (rs1_addr == rd_addr)) begin
        rs1      = wd;
        rs1_pend = 1'b0;
      end
      if (wr_ok && (rs2_addr == rd_addr)) begin
        rs2      = wd;
        rs2_pend = 1'b0;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wd;
  logic              alloc;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1;
  logic [DATA_W-1:0] rs2;
  logic              rs1_pend;
  logic              rs2_pend;
  logic              init_busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .rd_addr    (rd_addr),
    .wd         (wd),
    .alloc      (alloc),
    .alloc_addr (alloc_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_pend   (rs1_pend),
    .rs2_pend   (rs2_pend),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; alloc = 1'b0; rd_addr = '0; alloc_addr = '0; wd = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rs1_addr = ADDR_W'(a);
      rs2_addr = ADDR_W'(DEPTH - 1 - a);
      #1;
      check({tag, "_rs1"}, 32'(rs1), 32'h0);
      check({tag, "_rs2"}, 32'(rs2), 32'h0);
      check({tag, "_p1"}, 32'(rs1_pend), 32'h0);
      check({tag, "_p2"}, 32'(rs2_pend), 32'h0);
    end
  endtask

  task automatic write(input int a, input logic [DATA_W-1:0] d);
    we = 1'b1; rd_addr = ADDR_W'(a); wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    idle();
    rs1_addr = '0; rs2_addr = '0;
    rst = 1'b1;

    // Reset held three cycles
    tick();
    check("rst_busy", 32'(init_busy), 32'h1);
    check("rst_rs1", 32'(rs1), 32'h0);
    check("rst_pend", 32'(rs1_pend), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Sweep: busy for exactly 16 cycles, write/alloc attempts ignored
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("clr_busy%0d", i), 32'(init_busy), 32'h1);
      check($sformatf("clr_rs1_%0d", i), 32'(rs1), 32'h0);
      we = 1'b1; rd_addr = ADDR_W'((i + 15) % 16); wd = 19'h7FFFF;
      alloc = 1'b1; alloc_addr = ADDR_W'((i + 15) % 16);
      tick();
    end
    idle();
    check("clr_done", 32'(init_busy), 32'h0);
    check_all_zero("post_clr");

    // Basic write/read
    write(5, 19'h7FFFF);
    write(9, 19'h12345);
    rs1_addr = 4'd5; rs2_addr = 4'd9;
    #1;
    check("wr_r5", 32'(rs1), 32'h7FFFF);
    check("wr_r9", 32'(rs2), 32'h12345);

    // Zero register
    we = 1'b1; rd_addr = 4'd0; wd = 19'h55555;
    alloc = 1'b1; alloc_addr = 4'd0;
    tick();
    idle();
    rs1_addr = 4'd0;
    #1;
    check("zero_data", 32'(rs1), 32'h0);
    check("zero_pend", 32'(rs1_pend), 32'h0);

    // Scoreboard on r3
    alloc = 1'b1; alloc_addr = 4'd3;
    tick();
    idle();
    rs1_addr = 4'd3; rs2_addr = 4'd3;
    #1;
    check("sb_alloc_p1", 32'(rs1_pend), 32'h1);
    check("sb_alloc_p2", 32'(rs2_pend), 32'h1);
    we = 1'b1; rd_addr = 4'd3; wd = 19'h00ABC;
    alloc = 1'b1; alloc_addr = 4'd3;
    tick();
    idle();
    check("sb_both_pend", 32'(rs1_pend), 32'h1);
    check("sb_both_data", 32'(rs1), 32'h00ABC);
    write(3, 19'h00111);
    check("sb_wr_pend", 32'(rs1_pend), 32'h0);
    check("sb_wr_data", 32'(rs1), 32'h00111);
    rs2_addr = 4'd5;
    #1;
    check("sb_other", 32'(rs2_pend), 32'h0);

    // Bypass on r7 (pending beforehand)
    alloc = 1'b1; alloc_addr = 4'd7;
    tick();
    idle();
    rs1_addr = 4'd7; rs2_addr = 4'd7;
    we = 1'b1; rd_addr = 4'd7; wd = 19'h00F0F;
    #1;
    check("byp_rs1", 32'(rs1), BYP ? 32'h00F0F : 32'h0);
    check("byp_rs2", 32'(rs2), BYP ? 32'h00F0F : 32'h0);
    check("byp_p1", 32'(rs1_pend), BYP ? 32'h0 : 32'h1);
    check("byp_p2", 32'(rs2_pend), BYP ? 32'h0 : 32'h1);
    tick();
    idle();
    check("byp_next_rs1", 32'(rs1), 32'h00F0F);
    check("byp_next_rs2", 32'(rs2), 32'h00F0F);
    check("byp_next_p1", 32'(rs1_pend), 32'h0);

    // Fill entries and leave some pending, then reset mid-clear
    for (int a = 1; a < DEPTH; a++) write(a, 19'h40000 | 19'(a));
    alloc = 1'b1; alloc_addr = 4'd12;
    tick();
    idle();
    rs1_addr = 4'd12;
    #1;
    check("pre_rst_data", 32'(rs1), 32'h4000C);
    check("pre_rst_pend", 32'(rs1_pend), 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mid_busy%0d", i), 32'(init_busy), 32'h1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("re_busy%0d", i), 32'(init_busy), 32'h1);
      tick();
    end
    check("re_done", 32'(init_busy), 32'h0);
    check_all_zero("post_reclr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
